// File: rtl/snes_pkg.sv
// Shared types and constants for the SNES controller input arbiter.
package snes_pkg;

    localparam int SNES_FRAME_W = 16;

    localparam int BTN_B     = 0;
    localparam int BTN_Y     = 1;
    localparam int BTN_SEL   = 2;
    localparam int BTN_START = 3;
    localparam int BTN_UP    = 4;
    localparam int BTN_DOWN  = 5;
    localparam int BTN_LEFT  = 6;
    localparam int BTN_RIGHT = 7;
    localparam int BTN_A     = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_L     = 10;
    localparam int BTN_R     = 11;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'b00,
        MODE_AUTO  = 2'b01,
        MODE_MERGE = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LATCH = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } frame_st_e;

    // The unused encoding 2'b11 behaves as fixed mode.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return MODE_AUTO;
            2'b10:   return MODE_MERGE;
            default: return MODE_FIXED;
        endcase
    endfunction

endpackage

// File: rtl/snes_sync_edge.sv
// Two-flop synchronizer for a console-side line plus a one-cycle rising-edge pulse.
module snes_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;

endmodule

// File: rtl/snes_input_arbiter.sv
// Arbitrates several controller sources onto one SNES serial port and
// serves latch/clock frames to the console.
//
// state    | meaning
// ST_IDLE  | no frame since reset, output released
// ST_LATCH | latch high, shift register reloading every cycle
// ST_SHIFT | latch low, one bit shifted per console clock rise
// ST_DONE  | 16 bits sent, output driven low until next latch
module snes_input_arbiter
    import snes_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int BTN_W      = 12,
    parameter int HOLD_TICKS = 2000,
    localparam int SEL_W     = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH*BTN_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]       ch_valid,
    input  logic [1:0]              mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    snes_latch,
    input  logic                    snes_clk,
    output logic                    snes_out,
    output logic [SEL_W-1:0]        active_ch,
    output logic                    active_vld
);

    localparam int CNT_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS);

    logic [BTN_W-1:0]        ch_reg   [NUM_CH];
    logic [CNT_W-1:0]        hold_cnt [NUM_CH];
    logic [NUM_CH-1:0]       live_q;

    logic [SEL_W-1:0]        owner_q;
    logic                    owner_vld_q;

    frame_st_e               st_q, st_d;
    logic [SNES_FRAME_W-1:0] shift_q;
    logic [3:0]              bit_cnt_q;

    logic                    latch_level, latch_rise;
    logic                    clk_level, clk_rise;

    mode_e                   mode_cur;
    logic [BTN_W-1:0]        fixed_data, owner_data, merge_data, src_data;
    logic                    fixed_hit, fixed_live, owner_live, low_hit;
    logic [SEL_W-1:0]        low_idx;
    logic                    claim_hit;
    logic [SEL_W-1:0]        claim_idx;
    logic                    load, shift;

    snes_sync_edge u_sync_latch (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (snes_latch),
        .level    (latch_level),
        .rise     (latch_rise)
    );

    snes_sync_edge u_sync_clk (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (snes_clk),
        .level    (clk_level),
        .rise     (clk_rise)
    );

    // A fresh valid always reloads the hold timer, even mid-countdown.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_reg[i]   <= '0;
                hold_cnt[i] <= '0;
            end
            live_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid[i]) begin
                    ch_reg[i]   <= ch_data[i*BTN_W +: BTN_W];
                    hold_cnt[i] <= HOLD_LOAD;
                    live_q[i]   <= 1'b1;
                end else if (hold_cnt[i] != '0) begin
                    hold_cnt[i] <= hold_cnt[i] - 1'b1;
                    if (hold_cnt[i] == CNT_W'(1)) begin
                        ch_reg[i] <= '0;
                        live_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign mode_cur = decode_mode(mode);

    always_comb begin
        fixed_hit  = 1'b0;
        fixed_data = '0;
        fixed_live = 1'b0;
        owner_data = '0;
        owner_live = 1'b0;
        merge_data = '0;
        low_hit    = 1'b0;
        low_idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                fixed_hit  = 1'b1;
                fixed_data = ch_reg[i];
                fixed_live = live_q[i];
            end
            if (owner_q == SEL_W'(i)) begin
                owner_data = ch_reg[i];
                owner_live = owner_vld_q & live_q[i];
            end
            if (live_q[i]) begin
                merge_data = merge_data | ch_reg[i];
                if (!low_hit) begin
                    low_hit = 1'b1;
                    low_idx = SEL_W'(i);
                end
            end
        end
    end

    // Descending scan so the lowest qualifying channel wins a tie.
    always_comb begin
        claim_hit = 1'b0;
        claim_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_valid[i] && (ch_data[i*BTN_W +: BTN_W] != '0)) begin
                claim_hit = 1'b1;
                claim_idx = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
        end else if (!owner_live) begin
            owner_vld_q <= claim_hit && (mode_cur == MODE_AUTO);
            if (claim_hit && (mode_cur == MODE_AUTO)) begin
                owner_q <= claim_idx;
            end
        end
    end

    always_comb begin
        src_data   = '0;
        active_ch  = '0;
        active_vld = 1'b0;
        unique case (mode_cur)
            MODE_AUTO: begin
                if (owner_live) begin
                    src_data  = owner_data;
                    active_ch = owner_q;
                end
                active_vld = owner_live && (owner_data != '0);
            end
            MODE_MERGE: begin
                src_data   = merge_data;
                active_ch  = low_idx;
                active_vld = low_hit;
            end
            default: begin
                if (fixed_hit) begin
                    src_data  = fixed_data;
                    active_ch = sel;
                end
                active_vld = fixed_live && (fixed_data != '0);
            end
        endcase
    end

    always_comb begin
        st_d  = st_q;
        load  = 1'b0;
        shift = 1'b0;
        if (latch_rise) begin
            st_d = ST_LATCH;
            load = 1'b1;
        end else begin
            unique case (st_q)
                ST_LATCH: begin
                    if (latch_level) begin
                        load = 1'b1;
                    end else begin
                        st_d  = ST_SHIFT;
                        shift = clk_rise && clk_level;
                    end
                end
                ST_SHIFT: begin
                    if (clk_rise && clk_level) begin
                        shift = 1'b1;
                        if (bit_cnt_q == 4'd15) begin
                            st_d = ST_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Shift register holds active-high pressed; unused upper bits load as released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q      <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            st_q <= st_d;
            if (load) begin
                shift_q   <= SNES_FRAME_W'(src_data);
                bit_cnt_q <= '0;
            end else if (shift) begin
                shift_q   <= {1'b0, shift_q[SNES_FRAME_W-1:1]};
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
        end
    end

    assign snes_out = (st_q == ST_DONE) ? 1'b0 : ~shift_q[0];

endmodule

// File: tb/tb_snes_input_arbiter.sv
// Directed bench for snes_input_arbiter: fixed, auto, merge, hold timing and reset.
module tb_snes_input_arbiter;

    localparam int NUM_CH = 3;
    localparam int BTN_W  = 12;
    localparam int HOLD   = 200;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic [NUM_CH*BTN_W-1:0] ch_data = '0;
    logic [NUM_CH-1:0]       ch_valid = '0;
    logic [1:0]              mode = 2'b00;
    logic [1:0]              sel = 2'b00;
    logic                    snes_latch = 1'b0;
    logic                    snes_clk = 1'b0;
    logic                    snes_out;
    logic [1:0]              active_ch;
    logic                    active_vld;

    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    logic [15:0] rd;

    snes_input_arbiter #(
        .NUM_CH     (NUM_CH),
        .BTN_W      (BTN_W),
        .HOLD_TICKS (HOLD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .mode       (mode),
        .sel        (sel),
        .snes_latch (snes_latch),
        .snes_clk   (snes_clk),
        .snes_out   (snes_out),
        .active_ch  (active_ch),
        .active_vld (active_vld)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        ch_valid = '0;
        snes_latch = 1'b0;
        snes_clk = 1'b0;
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(3);
    endtask

    task automatic send(input logic [NUM_CH-1:0] v, input logic [NUM_CH*BTN_W-1:0] d);
        @(negedge clk);
        ch_data = d;
        ch_valid = v;
        @(negedge clk);
        ch_valid = '0;
    endtask

    task automatic latch_pulse();
        @(negedge clk);
        snes_latch = 1'b1;
        wait_cyc(4);
        snes_latch = 1'b0;
        wait_cyc(4);
    endtask

    task automatic clk_pulse();
        snes_clk = 1'b1;
        wait_cyc(4);
        snes_clk = 1'b0;
        wait_cyc(4);
    endtask

    task automatic read_bits(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            rd[first+k] = snes_out;
            clk_pulse();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_cyc(3);
        compared++; if (snes_out !== 1'b1) begin mismatched++; $display("FAIL reset_out: got %b want 1", snes_out); end
        compared++; if (active_ch !== 2'd0) begin mismatched++; $display("FAIL reset_ch: got %0d want 0", active_ch); end
        compared++; if (active_vld !== 1'b0) begin mismatched++; $display("FAIL reset_vld: got %b want 0", active_vld); end
        reset_n = 1'b1;
        wait_cyc(3);
        compared++; if (snes_out !== 1'b1) begin mismatched++; $display("FAIL idle_out: got %b want 1", snes_out); end
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 2'b00;
        sel = 2'd1;
        send(3'b010, {12'h000, 12'h001, 12'h000});
        compared++; if (active_vld !== 1'b1) begin mismatched++; $display("FAIL fixed_vld: got %b want 1", active_vld); end
        compared++; if (active_ch !== 2'd1) begin mismatched++; $display("FAIL fixed_ch: got %0d want 1", active_ch); end
        latch_pulse();
        read_bits(0, 16);
        compared++; if (rd !== 16'hFFFE) begin mismatched++; $display("FAIL fixed_frame: got %h want fffe", rd); end
        compared++; if (snes_out !== 1'b0) begin mismatched++; $display("FAIL fixed_after16: got %b want 0", snes_out); end
        clk_pulse();
        compared++; if (snes_out !== 1'b0) begin mismatched++; $display("FAIL fixed_after17: got %b want 0", snes_out); end
    endtask

    task automatic test_fixed_none();
        do_reset();
        mode = 2'b11;
        sel = 2'd3;
        send(3'b011, {12'h000, 12'h0F0, 12'h00F});
        compared++; if (active_vld !== 1'b0) begin mismatched++; $display("FAIL none_vld: got %b want 0", active_vld); end
        latch_pulse();
        read_bits(0, 16);
        compared++; if (rd !== 16'hFFFF) begin mismatched++; $display("FAIL none_frame: got %h want ffff", rd); end
    endtask

    task automatic test_auto();
        int t2;
        do_reset();
        mode = 2'b01;
        sel = 2'd0;
        send(3'b100, {12'h010, 12'h000, 12'h000});
        t2 = cyc;
        wait_cyc(99);
        send(3'b001, {12'h000, 12'h000, 12'h001});
        compared++; if (active_ch !== 2'd2) begin mismatched++; $display("FAIL auto_ch: got %0d want 2", active_ch); end
        compared++; if (active_vld !== 1'b1) begin mismatched++; $display("FAIL auto_vld: got %b want 1", active_vld); end
        latch_pulse();
        read_bits(0, 16);
        compared++; if (rd !== 16'hFFEF) begin mismatched++; $display("FAIL auto_frame: got %h want ffef", rd); end
        while (cyc < t2 + HOLD + 5) @(negedge clk);
        compared++; if (active_vld !== 1'b0) begin mismatched++; $display("FAIL auto_expire_vld: got %b want 0", active_vld); end
        latch_pulse();
        read_bits(0, 16);
        compared++; if (rd !== 16'hFFFF) begin mismatched++; $display("FAIL auto_expire_frame: got %h want ffff", rd); end
    endtask

    task automatic test_auto_tie();
        do_reset();
        mode = 2'b01;
        send(3'b011, {12'h000, 12'h004, 12'h002});
        compared++; if (active_ch !== 2'd0) begin mismatched++; $display("FAIL tie_ch: got %0d want 0", active_ch); end
        compared++; if (active_vld !== 1'b1) begin mismatched++; $display("FAIL tie_vld: got %b want 1", active_vld); end
        latch_pulse();
        read_bits(0, 16);
        compared++; if (rd !== 16'hFFFD) begin mismatched++; $display("FAIL tie_frame: got %h want fffd", rd); end
    endtask

    task automatic test_merge();
        do_reset();
        mode = 2'b10;
        send(3'b001, {12'h000, 12'h000, 12'h001});
        send(3'b010, {12'h000, 12'h800, 12'h000});
        compared++; if (active_vld !== 1'b1) begin mismatched++; $display("FAIL merge_vld: got %b want 1", active_vld); end
        compared++; if (active_ch !== 2'd0) begin mismatched++; $display("FAIL merge_ch: got %0d want 0", active_ch); end
        latch_pulse();
        read_bits(0, 16);
        compared++; if (rd !== 16'hF7FE) begin mismatched++; $display("FAIL merge_frame: got %h want f7fe", rd); end
    endtask

    task automatic test_mode_switch();
        do_reset();
        mode = 2'b00;
        sel = 2'd0;
        send(3'b011, {12'h000, 12'h3F0, 12'hA5C});
        latch_pulse();
        read_bits(0, 5);
        mode = 2'b10;
        read_bits(5, 11);
        compared++; if (rd !== 16'hF5A3) begin mismatched++; $display("FAIL switch_frame: got %h want f5a3", rd); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        mode = 2'b00;
        sel = 2'd0;
        send(3'b001, {12'h000, 12'h000, 12'h1F3});
        latch_pulse();
        read_bits(0, 8);
        compared++; if (rd[7:0] !== 8'h0C) begin mismatched++; $display("FAIL mid_first8: got %h want 0c", rd[7:0]); end
        compared++; if (snes_out !== 1'b0) begin mismatched++; $display("FAIL mid_bit8: got %b want 0", snes_out); end
        #20 reset_n = 1'b0;
        #1;
        compared++; if (snes_out !== 1'b1) begin mismatched++; $display("FAIL mid_reset_out: got %b want 1", snes_out); end
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(3);
        compared++; if (active_vld !== 1'b0) begin mismatched++; $display("FAIL mid_reset_vld: got %b want 0", active_vld); end
        send(3'b001, {12'h000, 12'h000, 12'h1F3});
        latch_pulse();
        read_bits(0, 16);
        compared++; if (rd !== 16'hFE0C) begin mismatched++; $display("FAIL mid_refresh_frame: got %h want fe0c", rd); end
        compared++; if (snes_out !== 1'b0) begin mismatched++; $display("FAIL mid_refresh_done: got %b want 0", snes_out); end
    endtask

    task automatic test_hold_reload();
        int t1;
        int t2;
        do_reset();
        mode = 2'b00;
        sel = 2'd0;
        send(3'b001, {12'h000, 12'h000, 12'h004});
        t1 = cyc;
        while (cyc < t1 + 150) @(negedge clk);
        send(3'b001, {12'h000, 12'h000, 12'h004});
        t2 = cyc;
        while (cyc < t1 + HOLD + 10) @(negedge clk);
        compared++; if (active_vld !== 1'b1) begin mismatched++; $display("FAIL hold_reload_vld: got %b want 1", active_vld); end
        while (cyc < t2 + HOLD - 1) @(negedge clk);
        compared++; if (active_vld !== 1'b1) begin mismatched++; $display("FAIL hold_last_cycle: got %b want 1", active_vld); end
        @(negedge clk);
        compared++; if (active_vld !== 1'b0) begin mismatched++; $display("FAIL hold_expired: got %b want 0", active_vld); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_fixed_none();
        test_auto();
        test_auto_tie();
        test_merge();
        test_mode_switch();
        test_reset_midframe();
        test_hold_reload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
